rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter.sv | 134 +++++++++++++
 tb/tb_rom_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : rom_arbiter
//  Purpose  : Two-port round-robin read arbiter in front of a synchronous ROM.
//             One read is in flight at a time. The address is registered,
//             the ROM registers its data, and the result goes back to the
//             granted port with a one-cycle ack pulse. An out-of-range
//             address skips the ROM and completes with zero data and err set.
//  Revision : 1.0 - initial release
// ============================================================================
module rom_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 9,
    parameter int RANGE = 512
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_req,
    input  logic [DEPTH-1:0] a_addr,
    output logic             a_ack,
    output logic [WIDTH-1:0] a_data,
    output logic             a_err,
    input  logic             b_req,
    input  logic [DEPTH-1:0] b_addr,
    output logic             b_ack,
    output logic [WIDTH-1:0] b_data,
    output logic             b_err,
    output logic [DEPTH-1:0] rom_addr,
    input  logic [WIDTH-1:0] rom_dout,
    output logic             busy
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ADDR = 2'd1;
    localparam logic [1:0] c_DATA = 2'd2;
    localparam logic [1:0] c_ACK  = 2'd3;

    // One extra bit so that RANGE == 2**DEPTH stays representable.
    localparam logic [DEPTH:0] c_RANGE = RANGE[DEPTH:0];

    logic [1:0]       r_state;
    logic             r_gnt_b;      // 1: port B owns the current read
    logic             r_last_b;     // 1: port B was granted most recently
    logic [DEPTH-1:0] r_rom_addr;
    logic             r_a_ack;
    logic [WIDTH-1:0] r_a_data;
    logic             r_a_err;
    logic             r_b_ack;
    logic [WIDTH-1:0] r_b_data;
    logic             r_b_err;

    logic             w_pick_b;
    logic             w_oor;

    // B wins when it is the only requester, or on a tie when A went last.
    assign w_pick_b = b_req && (!a_req || !r_last_b);
    assign w_oor    = ({1'b0, r_rom_addr} >= c_RANGE);

    // Arbitration, ROM sequencing and per-port result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_gnt_b    <= 1'b0;
            r_last_b   <= 1'b1;
            r_rom_addr <= '0;
            r_a_ack    <= 1'b0;
            r_a_data   <= '0;
            r_a_err    <= 1'b0;
            r_b_ack    <= 1'b0;
            r_b_data   <= '0;
            r_b_err    <= 1'b0;
        end else begin
            r_a_ack <= 1'b0;
            r_b_ack <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (a_req || b_req) begin
                        r_gnt_b    <= w_pick_b;
                        r_last_b   <= w_pick_b;
                        r_rom_addr <= w_pick_b ? b_addr : a_addr;
                        r_state    <= c_ADDR;
                    end
                end
                c_ADDR: begin
                    if (w_oor) begin
                        // No ROM access: complete now with zero data and err.
                        if (r_gnt_b) begin
                            r_b_data <= '0;
                            r_b_err  <= 1'b1;
                            r_b_ack  <= 1'b1;
                        end else begin
                            r_a_data <= '0;
                            r_a_err  <= 1'b1;
                            r_a_ack  <= 1'b1;
                        end
                        r_state <= c_ACK;
                    end else begin
                        r_state <= c_DATA;
                    end
                end
                c_DATA: begin
                    if (r_gnt_b) begin
                        r_b_data <= rom_dout;
                        r_b_err  <= 1'b0;
                        r_b_ack  <= 1'b1;
                    end else begin
                        r_a_data <= rom_dout;
                        r_a_err  <= 1'b0;
                        r_a_ack  <= 1'b1;
                    end
                    r_state <= c_ACK;
                end
                c_ACK: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign a_ack    = r_a_ack;
    assign a_data   = r_a_data;
    assign a_err    = r_a_err;
    assign b_ack    = r_b_ack;
    assign b_data   = r_b_data;
    assign b_err    = r_b_err;
    assign rom_addr = r_rom_addr;
    assign busy     = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rom_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_rom_arbiter
//  Purpose  : Randomised self-checking bench for rom_arbiter against a
//             transaction-level reference model (grant rule + latency count).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rom_arbiter;

    localparam int WIDTH = 8;
    localparam int DEPTH = 9;
    localparam int RANGE = 300;
    localparam int NCYC  = 4000;

    logic             clk = 1'b0;
    logic             reset;
    logic             a_req, b_req;
    logic [DEPTH-1:0] a_addr, b_addr;
    logic             a_ack, b_ack, a_err, b_err, busy;
    logic [WIDTH-1:0] a_data, b_data;
    logic [DEPTH-1:0] rom_addr;
    logic [WIDTH-1:0] rom_dout = '0;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    int          m_t;      // edges since grant, 0 = idle
    int          m_lat;    // edge count at which the ack becomes visible
    int          m_win;    // 0 = A, 1 = B
    int          m_last;
    int          m_rom;
    logic [31:0] m_a_data, m_b_data;
    logic        m_a_err, m_b_err;
    bit          did_rst_a = 1'b0;

    rom_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RANGE(RANGE)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_data(a_data), .a_err(a_err),
        .b_req(b_req), .b_addr(b_addr), .b_ack(b_ack), .b_data(b_data), .b_err(b_err),
        .rom_addr(rom_addr), .rom_dout(rom_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    // synchronous ROM: word[k] = k & 0xFF
    always @(posedge clk) rom_dout <= rom_addr[7:0];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_lat = 0; m_win = 0; m_last = 1; m_rom = 0;
        m_a_data = 0; m_b_data = 0; m_a_err = 0; m_b_err = 0;
    endtask

    // one rising edge of the reference model
    task automatic model_step();
        logic [31:0] val;
        logic        err;
        if (reset) begin
            model_reset();
        end else if (m_t == 0) begin
            if (a_req || b_req) begin
                if (a_req && b_req) m_win = 1 - m_last;
                else                m_win = b_req ? 1 : 0;
                m_last = m_win;
                m_rom  = m_win ? int'(b_addr) : int'(a_addr);
                m_lat  = (m_rom < RANGE) ? 3 : 2;
                m_t    = 1;
            end
        end else if (m_t == m_lat) begin
            m_t = 0;
        end else begin
            m_t++;
            if (m_t == m_lat) begin
                val = (m_rom < RANGE) ? 32'(m_rom % 256) : 32'd0;
                err = (m_rom >= RANGE);
                if (m_win == 1) begin m_b_data = val; m_b_err = err; end
                else            begin m_a_data = val; m_a_err = err; end
            end
        end
    endtask

    function automatic bit exp_ack(input int port);
        return (m_t != 0) && (m_t == m_lat) && (m_win == port);
    endfunction

    task automatic check_all();
        check("a_ack",    32'(a_ack),    32'(exp_ack(0)));
        check("b_ack",    32'(b_ack),    32'(exp_ack(1)));
        check("a_data",   32'(a_data),   m_a_data);
        check("b_data",   32'(b_data),   m_b_data);
        check("a_err",    32'(a_err),    32'(m_a_err));
        check("b_err",    32'(b_err),    32'(m_b_err));
        check("busy",     32'(busy),     32'(m_t != 0));
        check("rom_addr", 32'(rom_addr), 32'(m_rom));
    endtask

    // next request/address for one port, honouring the hold-until-ack protocol
    task automatic next_req(input bit ack_now, input bit granted, input logic req_in,
                            input logic [DEPTH-1:0] addr_in,
                            output logic req_out, output logic [DEPTH-1:0] addr_out);
        int r;
        req_out  = req_in;
        addr_out = addr_in;
        if (ack_now) begin
            req_out  = ($urandom_range(0, 1) == 1);
            addr_out = DEPTH'($urandom_range(0, 511));
        end else if (!req_in) begin
            if ($urandom_range(0, 3) == 0) begin
                req_out  = 1'b1;
                addr_out = DEPTH'($urandom_range(0, 511));
            end
        end else if (granted) begin
            r = $urandom_range(0, 99);
            if (r < 5)      addr_out = DEPTH'($urandom_range(0, 511));
            else if (r < 8) req_out  = 1'b0;
        end
    endtask

    initial begin
        bit want_rst;
        reset  = 1'b1;
        a_req  = 1'b0; b_req  = 1'b0;
        a_addr = '0;   b_addr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all();
        // both ports contend straight out of reset: A must win first
        reset  = 1'b0;
        a_req  = 1'b1; a_addr = 9'h010;
        b_req  = 1'b1; b_addr = 9'h020;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_all();
            if (reset) begin
                reset = 1'b0;
            end else begin
                // reset during the DATA cycle of an in-range read
                want_rst = (cyc > 20) && (m_t == 2) && (m_lat == 3) &&
                           ((!did_rst_a && m_win == 0) || $urandom_range(0, 39) == 0);
                if (want_rst) begin
                    if (m_win == 0) did_rst_a = 1'b1;
                    reset = 1'b1;
                    #1;
                    model_reset();
                    check_all();
                end else begin
                    next_req(exp_ack(0), (m_t != 0) && (m_win == 0), a_req, a_addr, a_req, a_addr);
                    next_req(exp_ack(1), (m_t != 0) && (m_win == 1), b_req, b_addr, b_req, b_addr);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
